alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/opcode interface.
- Accepts one operation request at a time over a valid/ready handshake and drives registered operands and the 3-bit opcode into the ALU.
- Waits for the op-dependent latency: 1 cycle for combinational ops, MOD_LATENCY cycles for the sequential MOD path. Then captures the ALU result and less-than flag and returns them over a valid/ready response handshake.

---
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one op over valid/ready, drives registered operands/opcode,
// waits the op latency, returns the captured result. Optional macro: ALU_ISSUE_CTRL_STATS_EN.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MOD_LATENCY = 34
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_lt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_lt,
  output logic             rsp_err,
  output logic [31:0]      stat_count
);

  localparam int unsigned CW     = $clog2(MOD_LATENCY + 1);
  localparam logic [2:0]  OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // req_ready is kept as a flop that always mirrors (state == IDLE).
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'b000;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_lt    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_op    <= req_op;
            req_ready <= 1'b0;
            // Divide by zero never reaches the ALU; answer immediately with an error.
            if (req_op == OP_MOD && req_b == '0) begin
              state     <= RESP;
              rsp_data  <= '0;
              rsp_lt    <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state     <= EXEC;
              cnt       <= (req_op == OP_MOD) ? CW'(MOD_LATENCY) : CW'(1);
              alu_start <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_data  <= alu_result;
            rsp_lt    <= alu_lt;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_CTRL_STATS_EN
  logic [31:0] stat_q;

  // Counts every completed response handshake, error responses included.
  always_ff @(posedge CLK) begin
    if (!reset)                         stat_q <= '0;
    else if (state == RESP && rsp_ready) stat_q <= stat_q + 32'd1;
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ML    = 34;

  logic             CLK = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;
  logic             alu_lt;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_lt, rsp_err;
  logic [31:0]      stat_count;

  alu_issue_ctrl #(.WIDTH(WIDTH), .MOD_LATENCY(ML)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_lt(rsp_lt), .rsp_err(rsp_err), .stat_count(stat_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_start = 0;
  int exp_stat = 0;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return (a < b) ? 32'd1 : 32'd0;
      3'd5:    return a + b;
      3'd6:    return a - b;
      default: return (b == 0) ? 32'd0 : a % b;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);
  assign alu_lt     = (alu_a < alu_b);

  always @(negedge CLK) if (alu_start) n_start++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] stat_exp();
`ifdef ALU_ISSUE_CTRL_STATS_EN
    return 32'(exp_stat);
`else
    return 32'd0;
`endif
  endfunction

  // Issue one op from an idle-ready cycle, check latency and response, hold the response
  // for 'hold' cycles (optionally with a pending request on req_valid), then retire it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit pend, input logic [2:0] p_op,
                        input logic [31:0] p_a, input logic [31:0] p_b);
    bit          zero;
    int          exp_lat, lat, s0;
    bit          saw_ready, stable;
    logic [31:0] d0;
    logic        l0, e0;
    zero    = (op == 3'b111) && (b == 0);
    exp_lat = zero ? 0 : ((op == 3'b111) ? ML : 1);
    check("ready_before", req_ready, 1'b1);
    s0 = n_start;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("alu_op", alu_op, op);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    lat = 0; saw_ready = 1'b0;
    while (!rsp_valid && lat < ML + 5) begin
      if (req_ready) saw_ready = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("ready_busy", saw_ready, 1'b0);
    check("rsp_data", rsp_data, zero ? 32'd0 : ref_alu(op, a, b));
    check("rsp_lt", rsp_lt, zero ? 1'b0 : (a < b));
    check("rsp_err", rsp_err, zero);
    d0 = rsp_data; l0 = rsp_lt; e0 = rsp_err; stable = 1'b1;
    if (pend) begin
      req_valid = 1'b1; req_op = p_op; req_a = p_a; req_b = p_b;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      if (!rsp_valid || rsp_data !== d0 || rsp_lt !== l0 || rsp_err !== e0 || req_ready)
        stable = 1'b0;
    end
    check("rsp_stable", stable, 1'b1);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    exp_stat++;
    check("start_pulses", n_start - s0, zero ? 0 : 1);
    check("rsp_done", rsp_valid, 1'b0);
    check("ready_after", req_ready, 1'b1);
    check("hold_alu_a", alu_a, a);
    check("keep_data", rsp_data, d0);
    check("stat_count", stat_count, stat_exp());
  endtask

  task automatic simple_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int hold);
    run_op(op, a, b, hold, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    bit          any_valid;
    int          s0;
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_op", alu_op, 3'd0);
    check("rst_stat", stat_count, 32'd0);

    simple_op(3'b101, 32'd5, 32'd7, 0);
    simple_op(3'b100, 32'd3, 32'd9, 1);
    simple_op(3'b100, 32'd9, 32'd3, 0);
    simple_op(3'b111, 32'd23, 32'd5, 0);
    simple_op(3'b111, 32'd23, 32'd0, 2);
    // Backpressure with a second request already waiting on req_valid.
    run_op(3'b110, 32'd100, 32'd1, 5, 1'b1, 3'b010, 32'hF0F0, 32'h0FF0);
    run_op(3'b010, 32'hF0F0, 32'h0FF0, 0, 1'b0, 3'd0, 32'd0, 32'd0);

    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      simple_op(op, a, b, $urandom_range(0, 3));
    end

    // Reset in the middle of a MOD: the operation must vanish without a response.
    s0 = n_start;
    req_valid = 1'b1; req_op = 3'b111; req_a = 32'd23; req_b = 32'd5;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #1 reset = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    exp_stat = 0;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_alu_op", alu_op, 3'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    check("mid_rst_err", {rsp_lt, rsp_err, alu_start}, 3'b000);
    check("mid_rst_stat", stat_count, 32'd0);
    any_valid = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (rsp_valid || !req_ready) any_valid = 1'b1;
    end
    check("no_ghost_rsp", any_valid, 1'b0);
    check("mid_rst_starts", n_start - s0, 1);
    simple_op(3'b011, 32'h1234_5678, 32'h0F0F_0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
